// File: rtl/mvm_host_driver_if.sv
// Bundles the upstream job stream, downstream result stream and mvm core strobes.
// master is the driver's view; slave is the environment (source, sink and core).
interface mvm_host_driver_if #(
  parameter int b = 8
);
  logic [b-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [2*b-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           loadMatrix;
  logic           loadVector;
  logic           start;
  logic [b-1:0]   mvm_data;
  logic           done;
  logic [2*b-1:0] mvm_dout;

  modport master (
    input  in_data, in_valid, out_ready, done, mvm_dout,
    output in_ready, out_data, out_valid, loadMatrix, loadVector, start, mvm_data
  );

  modport slave (
    output in_data, in_valid, out_ready, done, mvm_dout,
    input  in_ready, out_data, out_valid, loadMatrix, loadVector, start, mvm_data
  );
endinterface

// File: rtl/mvm_host_driver.sv
// Buffers a full K*K+K job, replays it to the mvm core, captures K results and streams them out.
// Latency: loadMatrix the cycle after the last job word; y[0] one cycle after the last capture.
// Backpressure: in_ready only while collecting; out_data/out_valid hold while out_ready is low.
module mvm_host_driver #(
  parameter int K       = 4,
  parameter int logK    = 2,
  parameter int b       = 8,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  mvm_host_driver_if.master bus,
  output logic              busy,
  output logic              error
);

  localparam int JN   = K*K + K;
  localparam int WW   = $clog2(JN);
  localparam int CMAX = (TIMEOUT > K*K + 2) ? TIMEOUT : K*K + 2;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [WW-1:0]   LAST_WORD = WW'(JN - 1);
  localparam logic [CW-1:0]   A_END     = CW'(K*K + 1);
  localparam logic [CW-1:0]   X_END     = CW'(K + 1);
  localparam logic [CW-1:0]   C_END     = CW'(K - 1);
  // The start cycle is the first of the TIMEOUT cycles, so the last WAIT_DONE count is TIMEOUT-2.
  localparam logic [CW-1:0]   T_END     = CW'(TIMEOUT - 2);
  localparam logic [logK-1:0] LAST_Y    = logK'(K - 1);

  typedef enum logic [2:0] {
    COLLECT, LOAD_A, LOAD_X, KICK, WAIT_DONE, CAPTURE, DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [b-1:0]    jbuf [JN];
  logic [2*b-1:0]  ybuf [K];
  logic [WW-1:0]   widx;
  logic [logK-1:0] ridx;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   rd_idx;
  logic            in_hs, out_hs, a_word, x_word, timeout;

  always_ff @(posedge clk) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.loadMatrix = 1'b0;
    bus.loadVector = 1'b0;
    bus.start      = 1'b0;
    a_word         = 1'b0;
    x_word         = 1'b0;
    timeout        = 1'b0;
    case (state)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && widx == LAST_WORD) state_nxt = LOAD_A;
      end
      LOAD_A: begin
        bus.loadMatrix = (cnt == '0);
        a_word         = (cnt != '0) && (cnt != A_END);
        if (cnt == A_END) state_nxt = LOAD_X;
      end
      LOAD_X: begin
        bus.loadVector = (cnt == '0);
        x_word         = (cnt != '0) && (cnt != X_END);
        if (cnt == X_END) state_nxt = KICK;
      end
      KICK: begin
        bus.start = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.done) begin
          state_nxt = CAPTURE;
        end else if (cnt == T_END) begin
          timeout   = 1'b1;
          state_nxt = COLLECT;
        end
      end
      CAPTURE: begin
        if (cnt == C_END) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready && ridx == LAST_Y) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  assign in_hs  = bus.in_valid && bus.in_ready;
  assign out_hs = bus.out_valid && bus.out_ready;
  assign busy   = (state != COLLECT);

  // Vector words sit directly after the matrix in jbuf.
  assign rd_idx       = WW'(cnt - 1'b1) + ((state == LOAD_X) ? WW'(K*K) : '0);
  assign bus.mvm_data = (a_word || x_word) ? jbuf[rd_idx] : '0;
  assign bus.out_data = (state == DRAIN) ? ybuf[ridx] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      widx  <= '0;
      ridx  <= '0;
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      if (timeout) error <= 1'b1;
      if (state_nxt != state || state == COLLECT || state == DRAIN) cnt <= '0;
      else                                                          cnt <= cnt + 1'b1;
      if (in_hs)  widx <= (widx == LAST_WORD) ? '0 : widx + 1'b1;
      if (out_hs) ridx <= (ridx == LAST_Y) ? '0 : ridx + 1'b1;
    end
  end

  // Buffers are not reset; writes are suppressed during reset so a reset cycle cannot store a word.
  always_ff @(posedge clk) begin
    if (reset && in_hs)              jbuf[widx]        <= bus.in_data;
    if (reset && state == CAPTURE)   ybuf[logK'(cnt)]  <= bus.mvm_dout;
  end

endmodule

// File: tb/tb_mvm_host_driver.sv
// Randomised job stream, behavioural mvm core and a result scoreboard for mvm_host_driver.
module tb_mvm_host_driver;
  localparam int K   = 4;
  localparam int B   = 8;
  localparam int YW  = 2*B;
  localparam int TMO = 256;
  localparam int JN  = K*K + K;

  logic clk = 1'b0;
  logic reset, busy, error;

  mvm_host_driver_if #(.b(B)) bus();

  mvm_host_driver #(.K(K), .logK(2), .b(B), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int prot = 0, rdy_viol = 0;
  int rmode = 0;
  bit never_done = 1'b0;
  logic [B-1:0]  ja [K*K];
  logic [B-1:0]  jx [K];
  logic [YW-1:0] exp_q [$];
  logic [YW:0]   drv_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reference: y = A*x with signed b-bit operands, wrapped to 2b bits.
  function automatic logic [YW-1:0] ref_y(input int row);
    int acc = 0;
    for (int j = 0; j < K; j++) acc += int'($signed(ja[row*K + j])) * int'($signed(jx[j]));
    return YW'(acc);
  endfunction

  task automatic push_ref();
    for (int i = 0; i < K; i++) exp_q.push_back(ref_y(i));
  endtask

  task automatic push4(input logic [YW-1:0] y0, y1, y2, y3);
    exp_q.push_back(y0); exp_q.push_back(y1); exp_q.push_back(y2); exp_q.push_back(y3);
  endtask

  task automatic set_ident(input int scale);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) ja[i*K + j] = (i == j) ? B'(scale) : '0;
  endtask

  task automatic set_x(input int x0, x1, x2, x3);
    jx[0] = B'(x0); jx[1] = B'(x1); jx[2] = B'(x2); jx[3] = B'(x3);
  endtask

  task automatic set_rand();
    for (int i = 0; i < K*K; i++) ja[i] = B'($urandom);
    for (int i = 0; i < K; i++)   jx[i] = B'($urandom);
  endtask

  // vmode: 0 continuous, 1 in_valid toggles every cycle, 2 random gaps.
  task automatic send_job(input int vmode);
    bit ok;
    for (int w = 0; w < JN; w++) begin
      if (vmode == 2 && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        cyc_wait(int'($urandom_range(1, 3)));
      end
      bus.in_data  = (w < K*K) ? ja[w] : jx[w - K*K];
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 3000 && !ok; t++) begin
        @(negedge clk); ok = bus.in_ready;
        @(posedge clk); #1;
      end
      if (!ok) begin
        chk("in_accept_timeout", 32'(ok), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      if (vmode == 1) begin bus.in_valid = 1'b0; cyc_wait(1); end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = B'($urandom);
  endtask

  task automatic wait_idle(input int lim);
    for (int t = 0; t < lim; t++) begin
      if (!busy && exp_q.size() == 0) return;
      cyc_wait(1);
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Behavioural core: takes K*K then K words after the load strobes, answers start with done + y.
  logic [B-1:0] ca [K*K];
  logic [B-1:0] cx [K];
  int cmode = 0, cn = 0;
  initial begin
    logic [YW:0] e;
    int acc;
    bus.done = 1'b0; bus.mvm_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (drv_q.size() > 0) begin
        e = drv_q.pop_front();
        bus.done = e[YW]; bus.mvm_dout = e[YW-1:0];
      end else begin
        bus.done     = !never_done && ($urandom_range(0, 7) == 0);
        bus.mvm_dout = YW'($urandom);
      end
      @(negedge clk);
      if (!reset) begin
        cmode = 0; drv_q.delete();
      end else begin
        case (cmode)
          1: begin ca[cn] = bus.mvm_data; cn++; if (cn == K*K) cmode = 2; end
          3: begin cx[cn] = bus.mvm_data; cn++; if (cn == K) cmode = 4; end
          2, 4: begin
            chk(cmode == 2 ? "a_gap" : "x_gap",
                {21'd0, bus.loadMatrix, bus.loadVector, bus.start, bus.mvm_data}, 32'd0);
            cmode = 0;
          end
          default: if (bus.mvm_data != '0) prot++;
        endcase
        if (bus.loadMatrix) begin cmode = 1; cn = 0; end
        if (bus.loadVector) begin cmode = 3; cn = 0; end
        if (bus.start && !never_done) begin
          repeat ($urandom_range(0, 12)) drv_q.push_back({1'b0, YW'($urandom)});
          drv_q.push_back({1'b1, YW'($urandom)});
          for (int i = 0; i < K; i++) begin
            acc = 0;
            for (int j = 0; j < K; j++) acc += int'($signed(ca[i*K + j])) * int'($signed(cx[j]));
            drv_q.push_back({1'b0, YW'(acc)});
          end
        end
      end
    end
  end

  // Downstream sink: rmode 0 always ready, 1 stalls 5 cycles when out_valid rises, 2 random.
  initial begin
    bit ov_seen = 1'b0;
    int hold = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rmode == 1 && bus.out_valid && !ov_seen) hold = 5;
      ov_seen = bus.out_valid;
      if (hold > 0) begin bus.out_ready = 1'b0; hold--; end
      else if (rmode == 2) bus.out_ready = 1'($urandom);
      else bus.out_ready = 1'b1;
    end
  end

  // Monitor / scoreboard.
  logic ov_p = 1'b0, or_p = 1'b0, lm_p = 1'b0, lv_p = 1'b0, st_p = 1'b0, err_p = 1'b0;
  logic [YW-1:0] od_p = '0;
  int hs_cnt = 0, last_hs = 0, lm_c = 0, lv_c = 0, st_c = 0, first_c = 0, pop_i = 0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        hs_cnt = 0;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          hs_cnt++;
          if (hs_cnt == JN) begin last_hs = cyc; hs_cnt = 0; end
        end
        if (bus.loadMatrix) begin chk("lm_lat", cyc - last_hs, 1); lm_c = cyc; end
        if (bus.loadVector) begin chk("lv_lat", cyc - lm_c, K*K + 2); lv_c = cyc; end
        if (bus.start)      begin chk("start_lat", cyc - lv_c, K + 2); st_c = cyc; end
        if (error && !err_p) chk("err_lat", cyc - st_c, TMO);
        if (int'(bus.loadMatrix) + int'(bus.loadVector) + int'(bus.start) > 1) prot++;
        if ((bus.loadMatrix && lm_p) || (bus.loadVector && lv_p) || (bus.start && st_p)) prot++;
        if (busy == bus.in_ready) rdy_viol++;
        if (ov_p && !or_p) begin
          chk("hold_valid", 32'(bus.out_valid), 32'd1);
          chk("hold_data", 32'(bus.out_data), 32'(od_p));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out actual=%0h required=none", bus.out_data);
          end else begin
            chk("y", 32'(bus.out_data), 32'(exp_q.pop_front()));
            if (pop_i == 0) first_c = cyc;
            if (pop_i == K-1 && rmode == 0) chk("zero_bubble", cyc - first_c, K - 1);
            pop_i = (pop_i + 1) % K;
          end
        end
      end
      ov_p = bus.out_valid; or_p = bus.out_ready; od_p = bus.out_data;
      lm_p = bus.loadMatrix; lv_p = bus.loadVector; st_p = bus.start; err_p = error;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    cyc_wait(2);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_out", {15'd0, bus.out_valid, bus.out_data}, 32'd0);
    chk("rst_core", {21'd0, bus.loadMatrix, bus.loadVector, bus.start, bus.mvm_data}, 32'd0);
    @(posedge clk); #1; reset = 1'b1;

    // identity * {1,2,3,4}
    set_ident(1); set_x(1, 2, 3, 4); push4(1, 2, 3, 4);
    send_job(0); wait_idle(1000);

    // all -1 * {1,2,3,4} with toggling in_valid, then with a stalled sink
    for (int i = 0; i < K*K; i++) ja[i] = 8'hFF;
    push4(16'hFFF6, 16'hFFF6, 16'hFFF6, 16'hFFF6);
    send_job(1); wait_idle(1000);
    rmode = 1;
    push4(16'hFFF6, 16'hFFF6, 16'hFFF6, 16'hFFF6);
    send_job(0); wait_idle(1000);
    rmode = 0;

    // core never answers
    never_done = 1'b1;
    set_ident(1);
    send_job(0); wait_idle(1000);
    chk("err_set", 32'(error), 32'd1);
    never_done = 1'b0;
    set_x(5, 6, 7, 8); push4(5, 6, 7, 8);
    send_job(0); wait_idle(1000);
    chk("err_sticky", 32'(error), 32'd1);

    // reset during LOAD_A word 7
    set_rand();
    send_job(0);
    for (int t = 0; t < 50; t++) begin @(negedge clk); if (bus.loadMatrix) break; end
    repeat (8) begin @(posedge clk); #1; end
    chk("word7_before_rst", 32'(bus.mvm_data), 32'(ja[7]));
    reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_core", {21'd0, bus.loadMatrix, bus.loadVector, bus.start, bus.mvm_data}, 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_error", 32'(error), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_quiet", {29'd0, bus.loadMatrix, bus.loadVector, bus.start}, 32'd0);
    end
    @(posedge clk); #1;
    set_rand(); push_ref();
    send_job(2); wait_idle(1000);

    // back-to-back jobs
    set_ident(1); set_x(1, 2, 3, 4); push4(1, 2, 3, 4);
    send_job(0);
    set_ident(2); set_x(-1, -2, -3, -4); push4(16'hFFFE, 16'hFFFC, 16'hFFFA, 16'hFFF8);
    send_job(0); wait_idle(1000);

    // random jobs, random gaps and sink stalls
    rmode = 2;
    for (int n = 0; n < 8; n++) begin
      set_rand(); push_ref();
      send_job(2); wait_idle(2000);
    end
    rmode = 0;
    cyc_wait(4);

    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    chk("strobe_protocol", 32'(prot), 32'd0);
    chk("in_ready_vs_busy", 32'(rdy_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
